// File: rtl/updown_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : updown_counter_pkg                                           |
// | Description : Shared mode encoding and build-time options for the          |
// |               updown_counter block. The UPDOWN_COUNTER_SAT_EN macro makes   |
// |               the up and down modes saturate at the bounds.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package updown_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

endpackage : updown_counter_pkg
`default_nettype wire

// File: rtl/updown_counter_next.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : updown_counter_next                                          |
// | Description : Combinational next-count / next-direction / terminal-count    |
// |               logic. Saturating up/down when UPDOWN_COUNTER_SAT_EN is set.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 2**WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  mode_t            mode,
    input  logic             en,
    output logic [WIDTH-1:0] count_next,
    output logic             dir_next,
    output logic             tc_next
);

    // One guard bit keeps MOD-1+1 from aliasing to zero when MOD = 2**WIDTH.
    localparam logic [WIDTH:0] c_max  = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0] c_zero = '0;
    localparam logic [WIDTH:0] c_one  = (WIDTH+1)'(1);

    logic [WIDTH:0] w_cur;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;
    logic           w_at_max;
    logic           w_at_min;

    logic [WIDTH:0] w_up_cnt;
    logic           w_up_tc;
    logic [WIDTH:0] w_dn_cnt;
    logic           w_dn_tc;
    logic [WIDTH:0] w_pp_cnt;
    logic           w_pp_dir;
    logic           w_pp_tc;

    logic [WIDTH:0] w_nxt;
    logic           w_unused_msb;

    assign w_cur    = {1'b0, count};
    assign w_inc    = w_cur + c_one;
    assign w_dec    = w_cur - c_one;
    assign w_at_max = (w_cur == c_max);
    assign w_at_min = (w_cur == c_zero);

    always_comb begin
        w_up_cnt = w_inc;
        w_up_tc  = 1'b0;
        if (c_sat_en) begin
            if (w_at_max) begin
                w_up_cnt = w_cur;
            end else begin
                w_up_tc = (w_inc == c_max);
            end
        end else if (w_at_max) begin
            w_up_cnt = c_zero;
            w_up_tc  = 1'b1;
        end
    end

    always_comb begin
        w_dn_cnt = w_dec;
        w_dn_tc  = 1'b0;
        if (c_sat_en) begin
            if (w_at_min) begin
                w_dn_cnt = w_cur;
            end else begin
                w_dn_tc = (w_dec == c_zero);
            end
        end else if (w_at_min) begin
            w_dn_cnt = c_max;
            w_dn_tc  = 1'b1;
        end
    end

    // Bounce without repeating the bound value.
    always_comb begin
        w_pp_cnt = dir ? w_inc : w_dec;
        w_pp_dir = dir;
        w_pp_tc  = 1'b0;
        if (dir && w_at_max) begin
            w_pp_cnt = w_dec;
            w_pp_dir = 1'b0;
            w_pp_tc  = 1'b1;
        end else if (!dir && w_at_min) begin
            w_pp_cnt = w_inc;
            w_pp_dir = 1'b1;
            w_pp_tc  = 1'b1;
        end
    end

    always_comb begin
        w_nxt    = w_cur;
        dir_next = dir;
        tc_next  = 1'b0;
        if (en) begin
            case (mode)
                MODE_UP: begin
                    w_nxt    = w_up_cnt;
                    dir_next = 1'b1;
                    tc_next  = w_up_tc;
                end
                MODE_DOWN: begin
                    w_nxt    = w_dn_cnt;
                    dir_next = 1'b0;
                    tc_next  = w_dn_tc;
                end
                MODE_PING: begin
                    w_nxt    = w_pp_cnt;
                    dir_next = w_pp_dir;
                    tc_next  = w_pp_tc;
                end
                default: begin
                    w_nxt    = w_cur;
                    dir_next = dir;
                    tc_next  = 1'b0;
                end
            endcase
        end
    end

    assign count_next   = w_nxt[WIDTH-1:0];
    assign w_unused_msb = w_nxt[WIDTH];

endmodule : updown_counter_next
`default_nettype wire

// File: rtl/updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : updown_counter                                               |
// | Description : Modulo-MOD up/down/ping-pong counter with clear, clamped      |
// |               parallel load and terminal-count pulse. Build with           |
// |               UPDOWN_COUNTER_SAT_EN for saturating up/down modes.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MOD       = 2**WIDTH,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  mode_t            mode,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   c_mod       = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0]   c_max       = (WIDTH+1)'(MOD - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_tc;

    logic [WIDTH-1:0] w_step_count;
    logic             w_step_dir;
    logic             w_step_tc;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH-1:0] w_load_val;

    updown_counter_next #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next (
        .count      (r_count),
        .dir        (r_dir),
        .mode       (mode),
        .en         (en),
        .count_next (w_step_count),
        .dir_next   (w_step_dir),
        .tc_next    (w_step_tc)
    );

    // Out-of-range load data clamps to the top of the count range.
    assign w_load_ext = {1'b0, load_val};
    assign w_load_val = (w_load_ext >= c_mod) ? c_max[WIDTH-1:0] : load_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= c_reset_val;
            r_dir   <= 1'b1;
            r_tc    <= 1'b0;
        end else if (clear) begin
            r_count <= c_reset_val;
            r_dir   <= 1'b1;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_val;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_step_count;
            r_dir   <= w_step_dir;
            r_tc    <= w_step_tc;
        end
    end

    assign count = r_count;
    assign dir   = r_dir;
    assign tc    = r_tc;

endmodule : updown_counter
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// Bench for updown_counter: three instances (MOD 10, 5, 16) sharing stimulus,
// directed table/sequences plus randomized checks against a behavioural model.
module tb_updown_counter;
    import updown_counter_pkg::*;

    typedef struct {
        logic       clr;
        logic       ld;
        logic [3:0] lv;
        logic       e;
        mode_t      m;
        int         c;
        logic       d;
        logic       t;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       en = 1'b0;
    mode_t      mode = MODE_UP;

    logic [3:0] cnt0, cnt1, cnt2;
    logic       dir0, dir1, dir2;
    logic       tc0, tc1, tc2;

    int total = 0;
    int bad   = 0;

    int mods [3];
    int rvs  [3];
    int mc   [3];
    bit md   [3];
    bit mt   [3];

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_dut10 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .mode(mode), .count(cnt0), .dir(dir0), .tc(tc0));
    updown_counter #(.WIDTH(4), .MOD(5), .RESET_VAL(0)) u_dut5 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .mode(mode), .count(cnt1), .dir(dir1), .tc(tc1));
    updown_counter #(.WIDTH(4), .MOD(16), .RESET_VAL(3)) u_dut16 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .mode(mode), .count(cnt2), .dir(dir2), .tc(tc2));

`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] get_cnt(input int i);
        return (i == 0) ? cnt0 : (i == 1) ? cnt1 : cnt2;
    endfunction
    function automatic logic get_dir(input int i);
        return (i == 0) ? dir0 : (i == 1) ? dir1 : dir2;
    endfunction
    function automatic logic get_tc(input int i);
        return (i == 0) ? tc0 : (i == 1) ? tc1 : tc2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = rvs[i];
            md[i] = 1'b1;
            mt[i] = 1'b0;
        end
    endtask

    // Behavioural next state from the counting rules, using plain integers.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int m;
            m = mods[i];
            mt[i] = 1'b0;
            if (clear) begin
                mc[i] = rvs[i];
                md[i] = 1'b1;
            end else if (load) begin
                mc[i] = (int'(load_val) >= m) ? m - 1 : int'(load_val);
            end else if (en) begin
                case (mode)
                    MODE_UP: begin
                        md[i] = 1'b1;
                        if (SAT) begin
                            if (mc[i] < m - 1) begin
                                mc[i] = mc[i] + 1;
                                mt[i] = (mc[i] == m - 1);
                            end
                        end else begin
                            mc[i] = (mc[i] + 1) % m;
                            mt[i] = (mc[i] == 0);
                        end
                    end
                    MODE_DOWN: begin
                        md[i] = 1'b0;
                        if (SAT) begin
                            if (mc[i] > 0) begin
                                mc[i] = mc[i] - 1;
                                mt[i] = (mc[i] == 0);
                            end
                        end else begin
                            mt[i] = (mc[i] == 0);
                            mc[i] = (mc[i] + m - 1) % m;
                        end
                    end
                    MODE_PING: begin
                        if (md[i] && mc[i] == m - 1) begin
                            mc[i] = m - 2; md[i] = 1'b0; mt[i] = 1'b1;
                        end else if (!md[i] && mc[i] == 0) begin
                            mc[i] = 1; md[i] = 1'b1; mt[i] = 1'b1;
                        end else begin
                            mc[i] = md[i] ? mc[i] + 1 : mc[i] - 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_dut%0d_count", tag, i), 32'(get_cnt(i)), 32'(mc[i]));
            chk($sformatf("%s_dut%0d_dir", tag, i), 32'(get_dir(i)), 32'(md[i]));
            chk($sformatf("%s_dut%0d_tc", tag, i), 32'(get_tc(i)), 32'(mt[i]));
        end
    endtask

    initial begin
        vec_t tbl[$];
        int   pc [9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
        bit   pd [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        bit   pt [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

        mods = '{10, 5, 16};
        rvs  = '{0, 0, 3};

        // Directed table for the MOD=10 instance.
        for (int k = 1; k <= 12; k++) begin
            if (SAT)
                tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, MODE_UP, (k < 9) ? k : 9, 1'b1, (k == 9)});
            else
                tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, MODE_UP, k % 10, 1'b1, (k == 10)});
        end
        tbl.push_back('{1'b0, 1'b1, 4'd15, 1'b0, MODE_UP,   9, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, MODE_DOWN, 8, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd9,  1'b1, MODE_UP,   9, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'd4,  1'b1, MODE_UP,   0, 1'b1, 1'b0});
        if (SAT)
            tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, MODE_DOWN, 0, 1'b0, 1'b0});
        else
            tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, MODE_DOWN, 9, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'd3,  1'b1, MODE_UP,   3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, MODE_HOLD, 3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b0, MODE_UP,   3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, MODE_UP,   4, 1'b1, 1'b0});

        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[k]) begin
            clear = tbl[k].clr; load = tbl[k].ld; load_val = tbl[k].lv;
            en = tbl[k].e; mode = tbl[k].m;
            tick();
            chk($sformatf("tbl%0d_count", k), 32'(cnt0), 32'(tbl[k].c));
            chk($sformatf("tbl%0d_dir", k),   32'(dir0), 32'(tbl[k].d));
            chk($sformatf("tbl%0d_tc", k),    32'(tc0),  32'(tbl[k].t));
        end

        // Ping-pong on MOD=5 from count 0, dir 1.
        clear = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        chk("pp_start_count", 32'(cnt1), 32'd0);
        clear = 1'b0; en = 1'b1; mode = MODE_PING;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("pp%0d_count", k), 32'(cnt1), 32'(pc[k]));
            chk($sformatf("pp%0d_dir", k),   32'(dir1), 32'(pd[k]));
            chk($sformatf("pp%0d_tc", k),    32'(tc1),  32'(pt[k]));
        end

        // Full-range MOD=16: approach and pass the top bound.
        load = 1'b1; load_val = 4'd14; en = 1'b0; mode = MODE_UP;
        tick();
        chk("m16_load_count", 32'(cnt2), 32'd14);
        load = 1'b0; en = 1'b1;
        tick();
        chk("m16_step1_count", 32'(cnt2), 32'd15);
        chk("m16_step1_tc", 32'(tc2), SAT ? 32'd1 : 32'd0);
        tick();
        chk("m16_step2_count", 32'(cnt2), SAT ? 32'd15 : 32'd0);
        chk("m16_step2_tc", 32'(tc2), SAT ? 32'd0 : 32'd1);
        check_all("m16");

        // Asynchronous reset between edges.
        mode = MODE_DOWN;
        tick();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            clear    = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            mode     = mode_t'($urandom_range(0, 3));
            tick();
            check_all($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_updown_counter
`default_nettype wire
